// File: rtl/keypad_scan_module_pkg.sv
// rtl/keypad_scan_module_pkg.sv - shared FSM encodings, row patterns and key-map helpers
package keypad_scan_module_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [3:0] ROW_PAT_0 = 4'b1110;
    localparam logic [3:0] ROW_PAT_1 = 4'b1101;
    localparam logic [3:0] ROW_PAT_2 = 4'b1011;
    localparam logic [3:0] ROW_PAT_3 = 4'b0111;

    function automatic logic [3:0] row_pattern(input logic [1:0] idx);
        case (idx)
            2'd0:    row_pattern = ROW_PAT_0;
            2'd1:    row_pattern = ROW_PAT_1;
            2'd2:    row_pattern = ROW_PAT_2;
            default: row_pattern = ROW_PAT_3;
        endcase
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] m);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, m[i]};
        end
        return n;
    endfunction

    // Index of the highest set bit; only meaningful when exactly one bit is set.
    function automatic logic [3:0] bit_index16(input logic [15:0] m);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                k = 4'(i);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/keypad_scan_module_tick.sv
// rtl/keypad_scan_module_tick.sv - row dwell counter and row index sequencer
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tick         high in the last cycle of each row dwell (count == SCAN_DIV-1)
//   frame_end    tick while row_idx == 3
//   row_idx      currently driven row, 0..3
module keypad_tick #(
    parameter int SCAN_DIV = 40000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic       frame_end,
    output logic [1:0] row_idx
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick      = (cnt == LAST);
    assign frame_end = tick && (row_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            row_idx <= 2'd0;
        end else if (tick) begin
            cnt     <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_module.sv
// rtl/keypad_scan_module.sv - 4x4 matrix keypad scanner with frame debounce
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   col[3:0]     active-low keypad columns (asynchronous)
//   row[3:0]     active-low row drive, one bit low at a time
//   key_code     {row_idx, col_idx} of the last accepted key
//   key_valid    one-cycle pulse per accepted press
//   key_held     high from acceptance until the release is accepted
module keypad_scan_module
    import keypad_scan_module_pkg::*;
#(
    parameter int SCAN_DIV     = 40000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SCW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SCW-1:0] CNT_SAT  = SCW'(DEBOUNCE_CNT);
    localparam logic [SCW-1:0] CNT_LAST = SCW'(DEBOUNCE_CNT - 1);
    localparam bit SINGLE = (DEBOUNCE_CNT == 1);

    logic       tick;
    logic       frame_end;
    logic [1:0] row_idx;

    keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .frame_end (frame_end),
        .row_idx   (row_idx)
    );

    assign row = row_pattern(row_idx);

    logic [3:0] col_s1;
    logic [3:0] col_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= 4'hF;
            col_s2 <= 4'hF;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    logic [15:0] map;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map <= '0;
        end else if (tick) begin
            map[4*row_idx +: 4] <= ~col_s2;
        end
    end

    // The classifier only matters at frame end, when row 3 is being sampled,
    // so the fresh sample is spliced in place of the stale row-3 nibble.
    logic [15:0] frame_map;
    logic        is_one;
    logic [3:0]  one_idx;

    always_comb begin
        frame_map = {~col_s2, map[11:0]};
        is_one    = (popcount16(frame_map) == 5'd1);
        one_idx   = bit_index16(frame_map);
    end

    kp_state_t      state;
    logic [3:0]     cand;
    logic [SCW-1:0] stable_cnt;
    logic [SCW-1:0] rel_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cand       <= 4'd0;
            stable_cnt <= '0;
            rel_cnt    <= '0;
            key_code   <= 4'd0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    ST_IDLE: begin
                        if (is_one) begin
                            cand <= one_idx;
                            if (SINGLE) begin
                                state      <= ST_PRESSED;
                                stable_cnt <= CNT_SAT;
                                key_code   <= one_idx;
                                key_valid  <= 1'b1;
                                key_held   <= 1'b1;
                            end else begin
                                state      <= ST_DEBOUNCE;
                                stable_cnt <= SCW'(1);
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (is_one && one_idx == cand) begin
                            if (stable_cnt == CNT_LAST) begin
                                state      <= ST_PRESSED;
                                stable_cnt <= CNT_SAT;
                                key_code   <= cand;
                                key_valid  <= 1'b1;
                                key_held   <= 1'b1;
                            end else begin
                                stable_cnt <= stable_cnt + 1'b1;
                            end
                        end else if (is_one) begin
                            cand       <= one_idx;
                            stable_cnt <= SCW'(1);
                        end else begin
                            state      <= ST_IDLE;
                            stable_cnt <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        // Any single key keeps the press alive; a new key needs a full release.
                        if (!is_one) begin
                            if (SINGLE) begin
                                state    <= ST_IDLE;
                                key_held <= 1'b0;
                                rel_cnt  <= '0;
                            end else begin
                                state   <= ST_RELEASE;
                                rel_cnt <= SCW'(1);
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (is_one) begin
                            state   <= ST_PRESSED;
                            rel_cnt <= '0;
                        end else if (rel_cnt == CNT_LAST) begin
                            state      <= ST_IDLE;
                            rel_cnt    <= '0;
                            stable_cnt <= '0;
                            key_held   <= 1'b0;
                        end else begin
                            rel_cnt <= rel_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_module.sv
// tb/tb_keypad_scan_module.sv - scoreboard bench for keypad_scan_module
module tb_keypad_scan_module;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clk;
    logic       rst_n;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;
    int          cyc;
    int          vectors;
    int          errors;
    bit          done;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;

    exp_t exp_q[$];

    keypad_scan_module #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && pressed[r*4+c]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    // Posedges seen since reset release; a frame ends every FRAME edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [3:0] exp_row(input int c);
        logic [3:0] pats [4];
        pats[0] = 4'b1110;
        pats[1] = 4'b1101;
        pats[2] = 4'b1011;
        pats[3] = 4'b0111;
        return pats[(c / SCAN_DIV) % 4];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_key(input logic [3:0] code, input int frames);
        exp_t e;
        e.code = code;
        e.at   = cyc + frames * FRAME;
        exp_q.push_back(e);
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    // Monitor: row sequence every cycle, and each key_valid pulse against the scoreboard.
    always @(negedge clk) begin
        if (!done) begin
            check("row", row, exp_row(cyc));
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {28'd0, key_code}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_code", key_code, e.code);
                    check("pulse_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        vectors = 0;
        errors  = 0;
        done    = 1'b0;
        pressed = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_row", row, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        rst_n = 1'b1;

        // 1: key 6 held 10 frames
        pressed = 16'h1 << 6;
        expect_key(4'h6, DB);
        wait_frames(10);
        check("c1_held", key_held, 1'b1);
        check("c1_code", key_code, 4'h6);

        // 2: release, then press again and bounce the release
        pressed = '0;
        wait_frames(2);
        check("c2_held_mid", key_held, 1'b1);
        wait_frames(1);
        check("c2_released", key_held, 1'b0);
        pressed = 16'h1 << 6;
        expect_key(4'h6, DB);
        wait_frames(4);
        pressed = '0;
        wait_frames(1);
        pressed = 16'h1 << 6;
        wait_frames(1);
        check("c2_bounce_held", key_held, 1'b1);
        wait_frames(2);
        pressed = '0;
        wait_frames(3);
        check("c2_rel2", key_held, 1'b0);

        // 3: key F chatter on,off,on,on,on
        pressed = 16'h1 << 15;
        wait_frames(1);
        pressed = '0;
        wait_frames(1);
        pressed = 16'h1 << 15;
        expect_key(4'hF, DB);
        wait_frames(DB);
        check("c3_code", key_code, 4'hF);
        check("c3_held", key_held, 1'b1);
        wait_frames(2);
        pressed = '0;
        wait_frames(3);
        check("c3_rel", key_held, 1'b0);

        // 4: keys 1+2 ghost-rejected, then key 1 alone
        pressed = (16'h1 << 1) | (16'h1 << 2);
        wait_frames(6);
        check("c4_multi_held", key_held, 1'b0);
        pressed = 16'h1 << 1;
        expect_key(4'h1, DB);
        wait_frames(DB);
        check("c4_code", key_code, 4'h1);
        pressed = '0;
        wait_frames(3);
        check("c4_rel", key_held, 1'b0);

        // 5: key 5, add 9, drop 5 -> no pulse for 9 until full release
        pressed = 16'h1 << 5;
        expect_key(4'h5, DB);
        wait_frames(DB);
        check("c5_held", key_held, 1'b1);
        pressed = (16'h1 << 5) | (16'h1 << 9);
        wait_frames(1);
        pressed = 16'h1 << 9;
        wait_frames(1);
        check("c5_still_held", key_held, 1'b1);
        check("c5_code_kept", key_code, 4'h5);
        wait_frames(2);
        pressed = '0;
        wait_frames(3);
        check("c5_rel", key_held, 1'b0);
        pressed = 16'h1 << 9;
        expect_key(4'h9, DB);
        wait_frames(DB);
        check("c5_code9", key_code, 4'h9);
        pressed = '0;
        wait_frames(3);
        check("c5_rel9", key_held, 1'b0);

        // 6: reset mid-debounce of key 3
        pressed = 16'h1 << 3;
        wait_frames(2);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("c6_rst_row", row, 4'b1110);
        check("c6_rst_held", key_held, 1'b0);
        check("c6_rst_code", key_code, 4'h0);
        check("c6_rst_valid", key_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_key(4'h3, DB);
        wait_frames(DB);
        check("c6_code", key_code, 4'h3);
        check("c6_held", key_held, 1'b1);
        pressed = '0;
        wait_frames(4);
        check("c6_rel", key_held, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
